// File: rtl/map_pkg.sv
// -----------------------------------------------------------------------------
// map_pkg
// Shared constants, FSM state type and small helper functions for the
// map loader (stream writer side of the game-map store).
//   MAP_W / MAP_H  : map dimensions in cells
//   TILE_W         : tile code width
//   SYNC_BYTE      : frame start marker
//   TILE_WALL      : tile value used for reset and out-of-range reads
// -----------------------------------------------------------------------------
package map_pkg;

    localparam int MAP_W     = 6;
    localparam int MAP_H     = 6;
    localparam int TILE_W    = 4;
    localparam int MAP_CELLS = MAP_W * MAP_H;

    localparam int IDX_W = $clog2(MAP_CELLS);
    localparam int X_W   = $clog2(MAP_W);
    localparam int Y_W   = $clog2(MAP_H);

    localparam logic [7:0]        SYNC_BYTE = 8'hA5;
    localparam logic [TILE_W-1:0] TILE_WALL = {{(TILE_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        PEND  = 2'd3
    } state_t;

    // A tile byte is legal only when the bits above the tile code are zero.
    function automatic logic tile_byte_ok(input logic [7:0] b);
        return (b[7:TILE_W] == {(8-TILE_W){1'b0}});
    endfunction

    // True when (x, y) addresses a real map cell.
    function automatic logic cell_in_range(input logic [7:0] x, input logic [7:0] y);
        return (x < 8'(MAP_W)) && (y < 8'(MAP_H));
    endfunction

endpackage

// File: rtl/map_loader_if.sv
// -----------------------------------------------------------------------------
// map_loader_if
// Byte-stream handshake between a host/UART sender and the map loader.
//   s_valid : byte valid (sender)
//   s_data  : byte value (sender)
//   s_ready : loader can take the byte; transfer on s_valid && s_ready
// Modports: master = sender, slave = loader.
// -----------------------------------------------------------------------------
interface map_loader_if;

    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/map_bank.sv
// -----------------------------------------------------------------------------
// map_bank
// One MAP_W x MAP_H bank of tile storage.
//   clk, rst_n        : clock, asynchronous active-low reset (all cells -> wall)
//   i_we, i_wx, i_wy,
//   i_wdata           : single synchronous write port
//   i_rx, i_ry        : combinational read address (full 8-bit range)
//   o_rdata           : tile at (i_rx, i_ry); wall when outside the map
// -----------------------------------------------------------------------------
module map_bank
    import map_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [X_W-1:0]    i_wx,
    input  logic [Y_W-1:0]    i_wy,
    input  logic [TILE_W-1:0] i_wdata,
    input  logic [7:0]        i_rx,
    input  logic [7:0]        i_ry,
    output logic [TILE_W-1:0] o_rdata
);

    logic [TILE_W-1:0] r_mem [MAP_W][MAP_H];

    // Tile storage: whole bank returns to wall on reset, one cell written per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int x = 0; x < MAP_W; x++) begin
                for (int y = 0; y < MAP_H; y++) begin
                    r_mem[x][y] <= TILE_WALL;
                end
            end
        end else if (i_we) begin
            r_mem[i_wx][i_wy] <= i_wdata;
        end
    end

    // Read port: anything off the map reads as wall so the renderer never indexes garbage.
    always_comb begin
        o_rdata = TILE_WALL;
        if (cell_in_range(i_rx, i_ry)) begin
            o_rdata = r_mem[i_rx[X_W-1:0]][i_ry[Y_W-1:0]];
        end else begin
            o_rdata = TILE_WALL;
        end
    end

endmodule

// File: rtl/map_loader.sv
// -----------------------------------------------------------------------------
// map_loader
// Receives a framed byte stream (SYNC_BYTE, MAP_CELLS tile bytes, XOR checksum)
// and writes it into the shadow bank of a double-buffered map store. The new
// map becomes visible by an atomic bank swap once the checksum matches and the
// renderer is not holding map_lock.
//   clk, rst_n  : clock, asynchronous active-low reset
//   s_if        : byte stream (slave side)
//   map_lock    : renderer busy; defers a pending swap
//   rd_x, rd_y  : read address; rd_point is the active-bank tile (comb.)
//   load_busy   : frame in progress (LOAD, CHECK, PEND)
//   load_done   : one-cycle pulse in the cycle after the swap
//   load_err    : sticky error; cleared when the next sync byte is taken
//   map_valid   : a map has been loaded since reset
// -----------------------------------------------------------------------------
module map_loader
    import map_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    map_loader_if.slave       s_if,
    input  logic              map_lock,
    input  logic [7:0]        rd_x,
    input  logic [7:0]        rd_y,
    output logic [TILE_W-1:0] rd_point,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic              map_valid
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAP_CELLS - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(MAP_H - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [X_W-1:0]    r_wx;
    logic [Y_W-1:0]    r_wy;
    logic [7:0]        r_csum;
    logic              r_bank_sel;   // index of the bank the renderer reads
    logic              r_load_done;
    logic              r_load_err;
    logic              r_map_valid;

    logic              w_accept;
    logic              w_start;
    logic              w_write;
    logic              w_err;
    logic              w_swap;
    logic              w_we0;
    logic              w_we1;
    logic [TILE_W-1:0] w_rd0;
    logic [TILE_W-1:0] w_rd1;

    // The loader only stalls the stream while a verified map waits for the lock to drop.
    assign s_if.s_ready = (r_state != PEND);
    assign w_accept     = s_if.s_valid && s_if.s_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes for the datapath.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_write      = 1'b0;
        w_err        = 1'b0;
        w_swap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && (s_if.s_data == SYNC_BYTE)) begin
                    w_start      = 1'b1;
                    w_state_next = LOAD;
                end else begin
                    w_state_next = IDLE;
                end
            end
            LOAD: begin
                // Sync byte is ordinary data here; only the upper-bit check can abort.
                if (w_accept) begin
                    if (!tile_byte_ok(s_if.s_data)) begin
                        w_err        = 1'b1;
                        w_state_next = IDLE;
                    end else if (r_idx == IDX_LAST) begin
                        w_write      = 1'b1;
                        w_state_next = CHECK;
                    end else begin
                        w_write      = 1'b1;
                        w_state_next = LOAD;
                    end
                end else begin
                    w_state_next = LOAD;
                end
            end
            CHECK: begin
                if (w_accept) begin
                    if (s_if.s_data != r_csum) begin
                        w_err        = 1'b1;
                        w_state_next = IDLE;
                    end else if (map_lock) begin
                        w_state_next = PEND;
                    end else begin
                        w_swap       = 1'b1;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_state_next = CHECK;
                end
            end
            PEND: begin
                if (!map_lock) begin
                    w_swap       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = PEND;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Write cursor: idx and its (x, y) form advance together, y-inner; idx stops at the last cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= {IDX_W{1'b0}};
            r_wx  <= {X_W{1'b0}};
            r_wy  <= {Y_W{1'b0}};
        end else if (w_start) begin
            r_idx <= {IDX_W{1'b0}};
            r_wx  <= {X_W{1'b0}};
            r_wy  <= {Y_W{1'b0}};
        end else if (w_write && (r_idx != IDX_LAST)) begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_wy == Y_LAST) begin
                r_wy <= {Y_W{1'b0}};
                r_wx <= r_wx + X_W'(1);
            end else begin
                r_wy <= r_wy + Y_W'(1);
            end
        end
    end

    // Running XOR of accepted tile bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csum <= 8'h00;
        end else if (w_start) begin
            r_csum <= 8'h00;
        end else if (w_write) begin
            r_csum <= r_csum ^ s_if.s_data;
        end
    end

    // Bank select and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_sel  <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_map_valid <= 1'b0;
        end else begin
            r_load_done <= w_swap;
            if (w_swap) begin
                r_bank_sel  <= ~r_bank_sel;
                r_map_valid <= 1'b1;
            end
            if (w_start) begin
                r_load_err <= 1'b0;
            end else if (w_err) begin
                r_load_err <= 1'b1;
            end
        end
    end

    // Writes always target the bank the renderer is not reading.
    assign w_we0 = w_write &&  r_bank_sel;
    assign w_we1 = w_write && !r_bank_sel;

    map_bank u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we0),
        .i_wx    (r_wx),
        .i_wy    (r_wy),
        .i_wdata (s_if.s_data[TILE_W-1:0]),
        .i_rx    (rd_x),
        .i_ry    (rd_y),
        .o_rdata (w_rd0)
    );

    map_bank u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we1),
        .i_wx    (r_wx),
        .i_wy    (r_wy),
        .i_wdata (s_if.s_data[TILE_W-1:0]),
        .i_rx    (rd_x),
        .i_ry    (rd_y),
        .o_rdata (w_rd1)
    );

    assign rd_point  = r_bank_sel ? w_rd1 : w_rd0;
    assign load_busy = (r_state == LOAD) || (r_state == CHECK) || (r_state == PEND);
    assign load_done = r_load_done;
    assign load_err  = r_load_err;
    assign map_valid = r_map_valid;

endmodule

// File: tb/tb_map_loader.sv
// -----------------------------------------------------------------------------
// tb_map_loader
// Self-checking bench for map_loader: read-back tables for two loaded maps
// and the out-of-range cases, hand sequences for checksum/tile errors, the
// map_lock deferral and reset mid-frame, and an event scoreboard that expects
// each load_done / load_err in the order the frames were sent.
// -----------------------------------------------------------------------------
module tb_map_loader;
    import map_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       map_lock = 1'b0;
    logic [7:0] rd_x = 8'd0;
    logic [7:0] rd_y = 8'd0;
    logic [3:0] rd_point;
    logic       load_busy;
    logic       load_done;
    logic       load_err;
    logic       map_valid;

    map_loader_if s_if ();

    map_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_if      (s_if.slave),
        .map_lock  (map_lock),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_point  (rd_point),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err),
        .map_valid (map_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum logic {EV_DONE = 1'b0, EV_ERR = 1'b1} ev_t;
    ev_t exp_q[$];

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] exp;
    } rd_vec_t;

    rd_vec_t tab_a[6];
    rd_vec_t tab_c[5];
    rd_vec_t tab_oor[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rd(input string name, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] exp);
        rd_x = x;
        rd_y = y;
        #1;
        chk($sformatf("%s rd(%0d,%0d)", name, x, y), {28'd0, rd_point}, {28'd0, exp});
    endtask

    // Present one byte and hold it until the loader takes it; returns 1 time unit after the edge.
    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        s_if.s_valid = 1'b1;
        s_if.s_data  = b;
        while (!done) begin
            @(negedge clk);
            if (s_if.s_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                n++;
                if (n > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: byte %0h not accepted, required accept within 50 cycles", b);
                    done = 1'b1;
                end
            end
        end
        s_if.s_valid = 1'b0;
    endtask

    function automatic logic [7:0] pat_a(input int i);
        return 8'(i % 4);
    endfunction

    function automatic logic [7:0] pat_c(input int i);
        return 8'(i % 16);
    endfunction

    function automatic logic [7:0] csum_c();
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < MAP_CELLS; i++) c = c ^ pat_c(i);
        return c;
    endfunction

    // Event scoreboard plus one-cycle width check on load_done.
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done <= 1'b0;
            prev_err  <= 1'b0;
        end else begin
            if (prev_done) begin
                checks++;
                if (load_done) begin
                    errors++;
                    $display("FAIL done_width: load_done high %0d cycles, required 1", 2);
                end
            end
            if (load_done && !prev_done) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0] != EV_DONE) begin
                    errors++;
                    $display("FAIL sb_done: load_done pulse seen, expected event queue size %0d", exp_q.size());
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (load_err && !prev_err) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0] != EV_ERR) begin
                    errors++;
                    $display("FAIL sb_err: load_err rise seen, expected event queue size %0d", exp_q.size());
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            prev_done <= load_done;
            prev_err  <= load_err;
        end
    end

    initial begin
        int bad;
        // Map A: tile i = x*6+y is i%4.  Map C: tile i is i%16.
        tab_a[0] = '{8'd2, 8'd3, 4'd3};
        tab_a[1] = '{8'd5, 8'd5, 4'd3};
        tab_a[2] = '{8'd0, 8'd1, 4'd1};
        tab_a[3] = '{8'd0, 8'd0, 4'd0};
        tab_a[4] = '{8'd1, 8'd0, 4'd2};
        tab_a[5] = '{8'd3, 8'd2, 4'd0};
        tab_c[0] = '{8'd2, 8'd3, 4'd15};
        tab_c[1] = '{8'd5, 8'd5, 4'd3};
        tab_c[2] = '{8'd5, 8'd0, 4'd14};
        tab_c[3] = '{8'd1, 8'd4, 4'd10};
        tab_c[4] = '{8'd0, 8'd2, 4'd2};
        tab_oor[0] = '{8'd6,   8'd0,   4'd1};
        tab_oor[1] = '{8'd0,   8'd200, 4'd1};
        tab_oor[2] = '{8'd255, 8'd255, 4'd1};
        tab_oor[3] = '{8'd0,   8'd6,   4'd1};
        tab_oor[4] = '{8'd7,   8'd3,   4'd1};

        s_if.s_valid = 1'b0;
        s_if.s_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset state
        chk_rd("reset", 8'd0, 8'd0, 4'd1);
        chk_rd("reset", 8'd5, 8'd5, 4'd1);
        chk("reset map_valid", {31'd0, map_valid}, 32'd0);
        chk("reset s_ready",   {31'd0, s_if.s_ready}, 32'd1);
        chk("reset load_busy", {31'd0, load_busy}, 32'd0);
        chk("reset load_err",  {31'd0, load_err}, 32'd0);

        // 2: junk bytes dropped, then a good frame
        send_byte(8'h00);
        send_byte(8'h37);
        chk("junk load_busy", {31'd0, load_busy}, 32'd0);
        send_byte(SYNC_BYTE);
        chk("sync load_busy", {31'd0, load_busy}, 32'd1);
        for (int i = 0; i < MAP_CELLS; i++) send_byte(pat_a(i));
        chk_rd("pre-swap", 8'd2, 8'd3, 4'd1);
        exp_q.push_back(EV_DONE);
        send_byte(8'h00);
        chk("t2 load_done", {31'd0, load_done}, 32'd1);
        chk("t2 map_valid", {31'd0, map_valid}, 32'd1);
        chk("t2 load_busy", {31'd0, load_busy}, 32'd0);
        for (int k = 0; k < 6; k++) chk_rd("mapA", tab_a[k].x, tab_a[k].y, tab_a[k].exp);
        for (int k = 0; k < 5; k++) chk_rd("oorA", tab_oor[k].x, tab_oor[k].y, tab_oor[k].exp);

        // 3: bad checksum leaves the active map untouched
        send_byte(SYNC_BYTE);
        for (int i = 0; i < MAP_CELLS; i++) send_byte(8'h02);
        exp_q.push_back(EV_ERR);
        send_byte(8'h01);
        chk("t3 load_err",  {31'd0, load_err}, 32'd1);
        chk("t3 load_done", {31'd0, load_done}, 32'd0);
        chk("t3 load_busy", {31'd0, load_busy}, 32'd0);
        chk_rd("t3", 8'd2, 8'd3, 4'd3);

        // 4: illegal tile byte aborts; next sync clears the error
        send_byte(SYNC_BYTE);
        chk("t4 err cleared", {31'd0, load_err}, 32'd0);
        for (int i = 0; i < 5; i++) send_byte(pat_c(i));
        exp_q.push_back(EV_ERR);
        send_byte(8'h12);
        chk("t4 load_err",  {31'd0, load_err}, 32'd1);
        chk("t4 load_busy", {31'd0, load_busy}, 32'd0);
        chk("t4 s_ready",   {31'd0, s_if.s_ready}, 32'd1);
        chk_rd("t4", 8'd2, 8'd3, 4'd3);
        send_byte(SYNC_BYTE);
        chk("t4 resync err", {31'd0, load_err}, 32'd0);
        chk("t4 resync busy", {31'd0, load_busy}, 32'd1);

        // 5: map_lock defers the swap (sync byte value inside the frame is plain data)
        for (int i = 0; i < MAP_CELLS; i++) send_byte(pat_c(i));
        map_lock = 1'b1;
        send_byte(csum_c());
        chk("t5 s_ready",   {31'd0, s_if.s_ready}, 32'd0);
        chk("t5 busy",      {31'd0, load_busy}, 32'd1);
        chk("t5 no done",   {31'd0, load_done}, 32'd0);
        chk_rd("t5 locked", 8'd2, 8'd3, 4'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("t5 still pend", {31'd0, s_if.s_ready}, 32'd0);
        chk_rd("t5 locked later", 8'd2, 8'd3, 4'd3);
        exp_q.push_back(EV_DONE);
        map_lock = 1'b0;
        @(posedge clk);
        #1;
        chk("t5 load_done", {31'd0, load_done}, 32'd1);
        chk("t5 s_ready",   {31'd0, s_if.s_ready}, 32'd1);
        chk("t5 busy",      {31'd0, load_busy}, 32'd0);
        for (int k = 0; k < 5; k++) chk_rd("mapC", tab_c[k].x, tab_c[k].y, tab_c[k].exp);
        for (int k = 0; k < 5; k++) chk_rd("oorC", tab_oor[k].x, tab_oor[k].y, tab_oor[k].exp);

        // 6: reset in the middle of a frame
        send_byte(SYNC_BYTE);
        for (int i = 0; i < 10; i++) send_byte(8'h00);
        chk("t6 busy before", {31'd0, load_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        bad = 0;
        for (int x = 0; x < MAP_W; x++) begin
            for (int y = 0; y < MAP_H; y++) begin
                rd_x = 8'(x);
                rd_y = 8'(y);
                #0.1;
                if (rd_point !== 4'd1) bad++;
            end
        end
        chk("t6 non-wall cells", bad, 32'd0);
        chk("t6 busy",      {31'd0, load_busy}, 32'd0);
        chk("t6 map_valid", {31'd0, map_valid}, 32'd0);
        chk("t6 s_ready",   {31'd0, s_if.s_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6 after busy", {31'd0, load_busy}, 32'd0);
        chk_rd("t6 after", 8'd2, 8'd3, 4'd1);

        chk("scoreboard empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
